rtc_read_sequencer: RTL and testbench

//  Upstream feeder of the VGA clock display. Periodically sweeps the RTC chip's

---
 rtl/rtc_read_sequencer_pkg.sv | 53 +++++
 rtl/rtc_bus_cycle.sv | 146 ++++++++++++++
 rtl/rtc_read_sequencer.sv | 162 ++++++++++++++++
 tb/tb_rtc_read_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/rtc_read_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rtc_read_sequencer_pkg                                       |
// | Description : Shared definitions for the RTC read sequencer: register      |
// |               index constants (also used by the display for             |
// |               selector_dato), RTC address table and bus FSM encoding.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rtc_read_sequencer_pkg;

  // Upper bound on the number of swept registers (selector_dato is 4 bits)
  localparam int MAX_REGS = 16;

  // Register indices shared with the display side
  localparam logic [3:0] IDX_SEC       = 4'd0;
  localparam logic [3:0] IDX_MIN       = 4'd1;
  localparam logic [3:0] IDX_HOUR      = 4'd2;
  localparam logic [3:0] IDX_DAY       = 4'd3;
  localparam logic [3:0] IDX_MONTH     = 4'd4;
  localparam logic [3:0] IDX_YEAR      = 4'd5;
  localparam logic [3:0] IDX_TMR_SEC   = 4'd6;
  localparam logic [3:0] IDX_TMR_MIN   = 4'd7;
  localparam logic [3:0] IDX_TMR_HOUR  = 4'd8;

  // One read transaction on the multiplexed RTC bus
  typedef enum logic [2:0] {
    BUS_IDLE = 3'd0,
    BUS_ADDR = 3'd1,
    BUS_GAP  = 3'd2,
    BUS_DATA = 3'd3,
    BUS_REL  = 3'd4
  } bus_state_e;

  // RTC register address for a given sweep index; unused indices map to 0
  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    logic [7:0] a;
    case (idx)
      IDX_SEC:      a = 8'h00;
      IDX_MIN:      a = 8'h02;
      IDX_HOUR:     a = 8'h04;
      IDX_DAY:      a = 8'h07;
      IDX_MONTH:    a = 8'h08;
      IDX_YEAR:     a = 8'h09;
      IDX_TMR_SEC:  a = 8'h30;
      IDX_TMR_MIN:  a = 8'h31;
      IDX_TMR_HOUR: a = 8'h32;
      default:      a = 8'h00;
    endcase
    return a;
  endfunction

endpackage : rtc_read_sequencer_pkg
`default_nettype wire

// File: rtl/rtc_bus_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rtc_bus_cycle                                                |
// | Description : Runs one RTC read transaction (ADDR, GAP, DATA, REL), each  |
// |               phase PHASE_CYC cycles long. A start seen during the last   |
// |               REL cycle chains straight into the next ADDR phase. Bus     |
// |               outputs are registered from the next state so they change   |
// |               cleanly on the clock edge together with the state.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rtc_bus_cycle
  import rtc_read_sequencer_pkg::*;
#(
  parameter int PHASE_CYC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_ad_in,
  output logic       o_done,
  output logic       o_rdata_vld,
  output logic [7:0] o_rdata,
  output logic       o_cs_n,
  output logic       o_ad_sel,
  output logic       o_wr_n,
  output logic       o_rd_n,
  output logic [7:0] o_ad_out,
  output logic       o_ad_oe
);

  localparam int              PW           = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [PW-1:0]   C_PHASE_LAST = PW'(PHASE_CYC - 1);

  bus_state_e     r_state;
  bus_state_e     w_state_nxt;
  logic [PW-1:0]  r_phase;
  logic [PW-1:0]  w_phase_nxt;
  logic           w_phase_last;
  logic           w_accept;
  logic [7:0]     r_addr;
  logic [7:0]     w_addr_nxt;

  logic           r_cs_n,   w_cs_n;
  logic           r_ad_sel, w_ad_sel;
  logic           r_wr_n,   w_wr_n;
  logic           r_rd_n,   w_rd_n;
  logic           r_ad_oe,  w_ad_oe;
  logic [7:0]     r_ad_out, w_ad_out;

  // Next-state, phase timer and next-cycle bus levels
  always_comb begin
    w_phase_last = (r_phase == C_PHASE_LAST);
    w_state_nxt  = r_state;
    w_accept     = 1'b0;
    case (r_state)
      BUS_IDLE: begin
        if (i_start) begin
          w_state_nxt = BUS_ADDR;
          w_accept    = 1'b1;
        end
      end
      BUS_ADDR: if (w_phase_last) w_state_nxt = BUS_GAP;
      BUS_GAP:  if (w_phase_last) w_state_nxt = BUS_DATA;
      BUS_DATA: if (w_phase_last) w_state_nxt = BUS_REL;
      BUS_REL: begin
        if (w_phase_last) begin
          if (i_start) begin
            w_state_nxt = BUS_ADDR;
            w_accept    = 1'b1;
          end else begin
            w_state_nxt = BUS_IDLE;
          end
        end
      end
      default: w_state_nxt = BUS_IDLE;
    endcase

    w_phase_nxt = (w_phase_last || r_state == BUS_IDLE) ? '0 : r_phase + 1'b1;
    w_addr_nxt  = w_accept ? i_addr : r_addr;

    // Bus levels for the state being entered; GAP and REL keep the
    // driver and the RTC read strobe apart during turnaround.
    w_cs_n   = 1'b1;
    w_ad_sel = 1'b0;
    w_wr_n   = 1'b1;
    w_rd_n   = 1'b1;
    w_ad_oe  = 1'b0;
    w_ad_out = 8'h00;
    case (w_state_nxt)
      BUS_ADDR: begin
        w_cs_n   = 1'b0;
        w_wr_n   = 1'b0;
        w_ad_oe  = 1'b1;
        w_ad_out = w_addr_nxt;
      end
      BUS_GAP: begin
        w_cs_n   = 1'b0;
      end
      BUS_DATA: begin
        w_cs_n   = 1'b0;
        w_ad_sel = 1'b1;
        w_rd_n   = 1'b0;
      end
      default: ;
    endcase
  end

  // State, phase timer, latched address and registered bus pins
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= BUS_IDLE;
      r_phase  <= '0;
      r_addr   <= 8'h00;
      r_cs_n   <= 1'b1;
      r_ad_sel <= 1'b0;
      r_wr_n   <= 1'b1;
      r_rd_n   <= 1'b1;
      r_ad_oe  <= 1'b0;
      r_ad_out <= 8'h00;
    end else begin
      r_state  <= w_state_nxt;
      r_phase  <= w_phase_nxt;
      r_addr   <= w_addr_nxt;
      r_cs_n   <= w_cs_n;
      r_ad_sel <= w_ad_sel;
      r_wr_n   <= w_wr_n;
      r_rd_n   <= w_rd_n;
      r_ad_oe  <= w_ad_oe;
      r_ad_out <= w_ad_out;
    end
  end

  assign o_done      = (r_state == BUS_REL)  && w_phase_last;
  assign o_rdata_vld = (r_state == BUS_DATA) && w_phase_last;
  assign o_rdata     = i_ad_in;

  assign o_cs_n   = r_cs_n;
  assign o_ad_sel = r_ad_sel;
  assign o_wr_n   = r_wr_n;
  assign o_rd_n   = r_rd_n;
  assign o_ad_oe  = r_ad_oe;
  assign o_ad_out = r_ad_out;

endmodule : rtc_bus_cycle
`default_nettype wire

// File: rtl/rtc_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rtc_read_sequencer                                           |
// | Description : Periodically sweeps the RTC time/date/timer registers into  |
// |               a working bank, then commits the whole bank to a shadow     |
// |               bank in one cycle so the display never sees a half-updated  |
// |               time. The display reads the shadow via selector_dato/dato.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rtc_read_sequencer
  import rtc_read_sequencer_pkg::*;
#(
  parameter int PHASE_CYC   = 4,
  parameter int REFRESH_CYC = 1000000,
  parameter int NUM_REGS    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] selector_dato,
  output logic [7:0] dato,
  output logic       data_valid,
  output logic       rtc_cs_n,
  output logic       rtc_ad_sel,
  output logic       rtc_wr_n,
  output logic       rtc_rd_n,
  output logic [7:0] rtc_ad_out,
  output logic       rtc_ad_oe,
  input  logic [7:0] rtc_ad_in
);

  localparam int            RW             = (REFRESH_CYC > 1) ? $clog2(REFRESH_CYC) : 1;
  localparam logic [RW-1:0] C_REFRESH_LAST = RW'(REFRESH_CYC - 1);
  localparam logic [3:0]    C_IDX_LAST     = 4'(NUM_REGS - 1);

  logic [RW-1:0] r_refresh_cnt;
  logic          w_tick;
  logic          r_busy;
  logic [3:0]    r_idx;
  logic [3:0]    w_start_idx;
  logic [7:0]    w_bus_addr;
  logic          w_bus_start;
  logic          w_start_sweep;
  logic          w_next_reg;
  logic          w_commit;
  logic          w_done;
  logic          w_rdata_vld;
  logic [7:0]    w_rdata;
  logic [7:0]    w_rd_byte;
  logic [7:0]    r_dato;
  logic          r_data_valid;

  logic [7:0]    r_working [NUM_REGS];
  logic [7:0]    r_shadow  [NUM_REGS];

  // Refresh period counter; a tick is raised whenever it sits at zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_refresh_cnt <= '0;
    end else if (r_refresh_cnt == C_REFRESH_LAST) begin
      r_refresh_cnt <= '0;
    end else begin
      r_refresh_cnt <= r_refresh_cnt + 1'b1;
    end
  end

  // Sweep sequencing: a tick starts a sweep when idle (or exactly as the
  // previous one commits); a tick during an active sweep is dropped.
  always_comb begin
    w_tick        = (r_refresh_cnt == '0);
    w_commit      = w_done && (r_idx == C_IDX_LAST);
    w_next_reg    = w_done && (r_idx != C_IDX_LAST);
    w_start_sweep = w_tick && (!r_busy || w_commit);
    w_bus_start   = w_start_sweep || w_next_reg;
    w_start_idx   = w_start_sweep ? 4'd0 : r_idx + 4'd1;
    w_bus_addr    = rtc_addr(w_start_idx);
  end

  // Sweep index and busy flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= 1'b0;
      r_idx  <= 4'd0;
    end else begin
      if (w_start_sweep) begin
        r_busy <= 1'b1;
        r_idx  <= 4'd0;
      end else if (w_next_reg) begin
        r_idx  <= r_idx + 4'd1;
      end else if (w_commit) begin
        r_busy <= 1'b0;
        r_idx  <= 4'd0;
      end
    end
  end

  rtc_bus_cycle #(
    .PHASE_CYC (PHASE_CYC)
  ) u_bus (
    .clk         (clk),
    .reset       (reset),
    .i_start     (w_bus_start),
    .i_addr      (w_bus_addr),
    .i_ad_in     (rtc_ad_in),
    .o_done      (w_done),
    .o_rdata_vld (w_rdata_vld),
    .o_rdata     (w_rdata),
    .o_cs_n      (rtc_cs_n),
    .o_ad_sel    (rtc_ad_sel),
    .o_wr_n      (rtc_wr_n),
    .o_rd_n      (rtc_rd_n),
    .o_ad_out    (rtc_ad_out),
    .o_ad_oe     (rtc_ad_oe)
  );

  // Working bank captures each byte; shadow takes the whole bank on commit
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_working[i] <= 8'h00;
        r_shadow[i]  <= 8'h00;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_rdata_vld && (r_idx == 4'(i))) begin
          r_working[i] <= w_rdata;
        end
        if (w_commit) begin
          r_shadow[i] <= r_working[i];
        end
      end
    end
  end

  // Read mux; during the commit cycle the working bank is forwarded so the
  // new value appears on the very next cycle. Unswept indices read as zero.
  always_comb begin
    w_rd_byte = 8'h00;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (selector_dato == 4'(i)) begin
        w_rd_byte = w_commit ? r_working[i] : r_shadow[i];
      end
    end
  end

  // Registered read port and first-commit flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dato       <= 8'h00;
      r_data_valid <= 1'b0;
    end else begin
      r_dato <= w_rd_byte;
      if (w_commit) begin
        r_data_valid <= 1'b1;
      end
    end
  end

  assign dato       = r_dato;
  assign data_valid = r_data_valid;

endmodule : rtc_read_sequencer
`default_nettype wire

// File: tb/tb_rtc_read_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rtc_read_sequencer                                        |
// | Description : Directed bench for rtc_read_sequencer with an RTC bus model |
// |               returning addr^A5, a bus-protocol monitor and a queue-based |
// |               scoreboard for the 1-cycle read port.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rtc_read_sequencer;

  localparam int         PHASE_CYC   = 2;
  localparam int         REFRESH_CYC = 200;
  localparam int         NUM_REGS    = 9;
  localparam int         SWEEP_LEN   = 4 * PHASE_CYC * NUM_REGS;
  localparam logic [7:0] NEW2        = 8'h37;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] selector_dato = 4'd0;
  logic [7:0] dato;
  logic       data_valid;
  logic       rtc_cs_n;
  logic       rtc_ad_sel;
  logic       rtc_wr_n;
  logic       rtc_rd_n;
  logic [7:0] rtc_ad_out;
  logic       rtc_ad_oe;
  logic [7:0] rtc_ad_in;

  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;
  bit         mon_en = 1'b0;
  bit         ovr = 1'b0;
  logic [7:0] mdl_addr = 8'h00;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  rtc_read_sequencer #(
    .PHASE_CYC   (PHASE_CYC),
    .REFRESH_CYC (REFRESH_CYC),
    .NUM_REGS    (NUM_REGS)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .selector_dato (selector_dato),
    .dato          (dato),
    .data_valid    (data_valid),
    .rtc_cs_n      (rtc_cs_n),
    .rtc_ad_sel    (rtc_ad_sel),
    .rtc_wr_n      (rtc_wr_n),
    .rtc_rd_n      (rtc_rd_n),
    .rtc_ad_out    (rtc_ad_out),
    .rtc_ad_oe     (rtc_ad_oe),
    .rtc_ad_in     (rtc_ad_in)
  );

  // Expected RTC address table (sec, min, hour, day, month, year, timer s/m/h)
  function automatic logic [7:0] tb_addr(input int k);
    case (k)
      0: return 8'h00;
      1: return 8'h02;
      2: return 8'h04;
      3: return 8'h07;
      4: return 8'h08;
      5: return 8'h09;
      6: return 8'h30;
      7: return 8'h31;
      8: return 8'h32;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] exp_byte(input int k, input bit o);
    if (k >= NUM_REGS) return 8'h00;
    if (k == 2 && o)   return NEW2;
    return tb_addr(k) ^ 8'hA5;
  endfunction

  // RTC model: latch address while WR is low, drive data while RD is low
  always @(posedge clk) begin
    if (!rtc_cs_n && !rtc_wr_n) mdl_addr <= rtc_ad_out;
  end
  assign rtc_ad_in = !rtc_rd_n ? ((ovr && mdl_addr == tb_addr(2)) ? NEW2 : (mdl_addr ^ 8'hA5))
                               : 8'hFF;

  // Cycle index relative to the last reset edge
  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic rd(input logic [3:0] s, input logic [7:0] e, input string tag);
    logic [7:0] x;
    selector_dato = s;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    chk(tag, {24'h0, dato}, {24'h0, x});
  endtask

  task automatic wait_until(input int target, input int budget, input string tag);
    int n = 0;
    while (cyc != target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cyc, target);
  endtask

  task automatic wait_dv(input string tag);
    int n = 0;
    while (!data_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, cyc, SWEEP_LEN + 1);
  endtask

  // Bus protocol monitor
  always @(negedge clk) begin
    if (mon_en) begin
      chk("oe_rd_overlap", {31'b0, rtc_ad_oe & ~rtc_rd_n}, 32'd0);
      if (!rtc_cs_n)
        chk("cs_window", {31'b0, ((cyc % REFRESH_CYC) >= 1) && ((cyc % REFRESH_CYC) <= SWEEP_LEN)}, 32'd1);
      if (!rtc_rd_n)
        chk("rd_phase", {29'b0, rtc_cs_n, rtc_ad_sel, rtc_wr_n}, 32'b011);
      if (!rtc_wr_n)
        chk("wr_phase", {29'b0, rtc_cs_n, rtc_ad_sel, rtc_ad_oe}, 32'b001);
      if ((cyc % REFRESH_CYC) == 1 && !reset)
        chk("sweep_start", {22'b0, rtc_wr_n, rtc_ad_oe, rtc_ad_out}, {22'b0, 1'b0, 1'b1, tb_addr(0)});
    end
  end

  initial begin
    int it;
    // Reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_strobes", {27'b0, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_ad_sel, rtc_ad_oe}, 32'b11100);
    chk("rst_ad_out", {24'b0, rtc_ad_out}, 32'h0);
    chk("rst_dato", {24'b0, dato}, 32'h0);
    chk("rst_dv", {31'b0, data_valid}, 32'h0);
    reset  = 1'b0;
    mon_en = 1'b1;

    // First sweep: data_valid exactly one sweep after the first ADDR
    wait_dv("t1_dv_latency");
    for (int k = 0; k < NUM_REGS; k++) rd(4'(k), exp_byte(k, 1'b0), "t1_read");

    // Out-of-range selectors
    rd(4'd12, 8'h00, "t3_sel12");
    chk("t3_known", {31'b0, $isunknown(dato)}, 32'd0);
    rd(4'd15, 8'h00, "t3_sel15");

    // Value change for index 2 during sweep 2; visible only after its commit
    wait_until(210, 400, "t2_wait");
    ovr = 1'b1;
    it  = 0;
    while (cyc < 285 && it < 200) begin
      rd(4'd2, exp_byte(2, cyc >= (REFRESH_CYC + SWEEP_LEN)), "t2_sel2");
      it++;
    end

    // Continuous selector sweep over the full index range
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 16; k++) rd(4'(k), exp_byte(k, 1'b1), "t6_table");

    // Let the monitor observe further sweeps at 401 and 601
    wait_until(3 * REFRESH_CYC + 20, 800, "t5_wait");
    chk("t5_dv_held", {31'b0, data_valid}, 32'd1);

    // Reset during DATA of index 5
    wait_until(3 * REFRESH_CYC + 5 * 4 * PHASE_CYC + 2 * PHASE_CYC + 1, 200, "t4_wait");
    chk("t4_in_data", {29'b0, rtc_rd_n, rtc_ad_sel, rtc_ad_oe}, 32'b010);
    chk("t4_idx5", {24'b0, mdl_addr}, {24'b0, tb_addr(5)});
    reset = 1'b1;
    @(negedge clk);
    chk("t4_strobes", {27'b0, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_ad_sel, rtc_ad_oe}, 32'b11100);
    chk("t4_dv", {31'b0, data_valid}, 32'd0);
    chk("t4_dato", {24'b0, dato}, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("t4_restart", {23'b0, rtc_wr_n, rtc_ad_out}, {23'b0, 1'b0, tb_addr(0)});
    rd(4'd2, 8'h00, "t4_shadow_clear");
    wait_dv("t4_dv_latency");
    for (int k = 0; k < NUM_REGS; k++) rd(4'(k), exp_byte(k, 1'b1), "t4_read");

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule : tb_rtc_read_sequencer
`default_nettype wire
